// File: rtl/bus_dev_fifo.sv
// First-word-fall-through FIFO between a device (push side) and the bus driver (pop side).
// Head data, pndng and full are decoded from registered state only; overflow and underflow are sticky.
module bus_dev_fifo #(
    parameter int unsigned width = 16,
    parameter int unsigned depth = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [width-1:0]       D_push,
    output logic                   full,
    input  logic                   pop,
    output logic [width-1:0]       D_pop,
    output logic                   pndng,
    output logic [$clog2(depth):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned aw = $clog2(depth);
    localparam int unsigned cw = aw + 1;

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wr_ptr;
    logic [aw-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // When full, a concurrent pop frees the slot, so the push is still accepted.
    always_comb begin
        pndng   = (count != '0);
        full    = (count == cw'(depth));
        do_pop  = pop && pndng;
        do_push = push && (!full || do_pop);
        D_pop   = pndng ? mem[rd_ptr] : '0;
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + aw'(1);
            if (do_pop)  rd_ptr <= rd_ptr + aw'(1);
            count <= count + cw'(do_push) - cw'(do_pop);
            if (push && !do_push) overflow  <= 1'b1;
            if (pop && !pndng)    underflow <= 1'b1;
        end
    end

    // Storage is never cleared; stale entries are hidden behind the pointers.
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= D_push;
    end

endmodule
